// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive path
// (NRZI/unstuff front end, SYNC detector, packet decoder).
package usb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ERROR  = 2'd2
    } rx_state_t;

    localparam logic LINE_J = 1'b1;
    localparam logic LINE_K = 1'b0;

    localparam int DEFAULT_MAX_ONES   = 6;
    localparam int DEFAULT_RESET_BITS = 30;

endpackage

// File: rtl/usb_nrzi_decoder.sv
// NRZI decoder: remembers the last non-SE0 line level and reports whether
// the current strobed level repeats it (decoded 1) or toggles (decoded 0).
module usb_nrzi_decoder
    import usb_rx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic bit_strobe_i,
    input  logic line_j_i,
    input  logic line_se0_i,
    input  logic clear_i,
    output logic decoded_o,
    output logic data_strobe_o
);

    logic prev_level_q;
    logic prev_level_d;

    assign data_strobe_o = bit_strobe_i & ~line_se0_i;
    assign decoded_o     = (line_j_i == prev_level_q);

    // Next line level: J when cleared, otherwise follow every non-SE0 strobe.
    always_comb begin
        prev_level_d = prev_level_q;
        if (clear_i) begin
            prev_level_d = LINE_J;
        end else if (data_strobe_o) begin
            prev_level_d = line_j_i;
        end else begin
            prev_level_d = prev_level_q;
        end
    end

    // Line level register with synchronous active-low reset to J.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_level_q <= LINE_J;
        end else begin
            prev_level_q <= prev_level_d;
        end
    end

endmodule

// File: rtl/usb_rx_nrzi_unstuff.sv
// Full-speed receive front end: NRZI decode, bit unstuffing, packet
// activity, stuff-error, EOP and bus-reset detection. All outputs registered.
module usb_rx_nrzi_unstuff
    import usb_rx_pkg::*;
#(
    parameter int MAX_ONES   = DEFAULT_MAX_ONES,
    parameter int RESET_BITS = DEFAULT_RESET_BITS
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_enable,
    input  logic bit_strobe,
    input  logic line_j,
    input  logic line_se0,
    output logic data_valid,
    output logic data_in,
    output logic rx_active,
    output logic stuff_err,
    output logic eop_detected,
    output logic usb_reset
);

    localparam int ONES_W = $clog2(MAX_ONES + 1);
    localparam int SE0_W  = $clog2(RESET_BITS + 1);

    rx_state_t          state_q, state_d;
    logic [ONES_W-1:0]  ones_cnt_q, ones_cnt_d;
    logic [SE0_W-1:0]   se0_cnt_q, se0_cnt_d;
    logic               data_valid_q, data_valid_d;
    logic               data_in_q, data_in_d;
    logic               rx_active_q, rx_active_d;
    logic               stuff_err_q, stuff_err_d;
    logic               eop_q, eop_d;
    logic               usb_reset_q, usb_reset_d;

    logic               decoded_s;
    logic               data_strobe_s;
    logic               clear_s;

    assign clear_s = ~rx_enable;

    usb_nrzi_decoder u_nrzi (
        .clk           (clk),
        .rst           (rst),
        .bit_strobe_i  (bit_strobe),
        .line_j_i      (line_j),
        .line_se0_i    (line_se0),
        .clear_i       (clear_s),
        .decoded_o     (decoded_s),
        .data_strobe_o (data_strobe_s)
    );

    // Unstuff FSM, counters and next values of the output pulses.
    always_comb begin
        state_d      = state_q;
        ones_cnt_d   = ones_cnt_q;
        se0_cnt_d    = se0_cnt_q;
        rx_active_d  = rx_active_q;
        data_valid_d = 1'b0;
        data_in_d    = 1'b0;
        stuff_err_d  = 1'b0;
        eop_d        = 1'b0;
        usb_reset_d  = 1'b0;

        if (!rx_enable) begin
            // Receiver muted while we transmit: drop any packet silently.
            state_d     = IDLE;
            rx_active_d = 1'b0;
            ones_cnt_d  = '0;
            se0_cnt_d   = '0;
        end else if (bit_strobe && line_se0) begin
            if (se0_cnt_q != SE0_W'(RESET_BITS)) begin
                se0_cnt_d = se0_cnt_q + SE0_W'(1);
            end else begin
                se0_cnt_d = se0_cnt_q;
            end
            // Pulse only on the transition into saturation, so one per reset.
            if (se0_cnt_q == SE0_W'(RESET_BITS - 1)) begin
                usb_reset_d = 1'b1;
                state_d     = IDLE;
                rx_active_d = 1'b0;
                ones_cnt_d  = '0;
            end else begin
                state_d = state_q;
            end
        end else if (data_strobe_s) begin
            se0_cnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (line_j == LINE_K) begin
                        state_d      = ACTIVE;
                        rx_active_d  = 1'b1;
                        ones_cnt_d   = '0;
                        data_valid_d = 1'b1;
                        data_in_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ACTIVE: begin
                    if ((se0_cnt_q != '0) && (line_j == LINE_J)) begin
                        eop_d       = 1'b1;
                        rx_active_d = 1'b0;
                        state_d     = IDLE;
                        ones_cnt_d  = '0;
                    end else if (decoded_s) begin
                        if (ones_cnt_q == ONES_W'(MAX_ONES)) begin
                            stuff_err_d = 1'b1;
                            state_d     = ERROR;
                        end else begin
                            data_valid_d = 1'b1;
                            data_in_d    = 1'b1;
                            ones_cnt_d   = ones_cnt_q + ONES_W'(1);
                        end
                    end else begin
                        // A zero after a full run of ones is the stuffed bit.
                        if (ones_cnt_q == ONES_W'(MAX_ONES)) begin
                            ones_cnt_d = '0;
                        end else begin
                            data_valid_d = 1'b1;
                            data_in_d    = 1'b0;
                            ones_cnt_d   = '0;
                        end
                    end
                end
                ERROR: begin
                    if ((se0_cnt_q != '0) && (line_j == LINE_J)) begin
                        eop_d       = 1'b1;
                        rx_active_d = 1'b0;
                        state_d     = IDLE;
                        ones_cnt_d  = '0;
                    end else begin
                        state_d = ERROR;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    rx_active_d = 1'b0;
                    ones_cnt_d  = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State, counter and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            ones_cnt_q   <= '0;
            se0_cnt_q    <= '0;
            data_valid_q <= 1'b0;
            data_in_q    <= 1'b0;
            rx_active_q  <= 1'b0;
            stuff_err_q  <= 1'b0;
            eop_q        <= 1'b0;
            usb_reset_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ones_cnt_q   <= ones_cnt_d;
            se0_cnt_q    <= se0_cnt_d;
            data_valid_q <= data_valid_d;
            data_in_q    <= data_in_d;
            rx_active_q  <= rx_active_d;
            stuff_err_q  <= stuff_err_d;
            eop_q        <= eop_d;
            usb_reset_q  <= usb_reset_d;
        end
    end

    assign data_valid   = data_valid_q;
    assign data_in      = data_in_q;
    assign rx_active    = rx_active_q;
    assign stuff_err    = stuff_err_q;
    assign eop_detected = eop_q;
    assign usb_reset    = usb_reset_q;

endmodule

// File: tb/tb_usb_rx_nrzi_unstuff.sv
// Self-checking bench for usb_rx_nrzi_unstuff: expected unstuffed bits are
// queued as line stimulus is generated and compared against captured output.
module tb_usb_rx_nrzi_unstuff;

    logic clk = 1'b0;
    logic rst;
    logic rx_enable;
    logic bit_strobe;
    logic line_j;
    logic line_se0;
    logic data_valid;
    logic data_in;
    logic rx_active;
    logic stuff_err;
    logic eop_detected;
    logic usb_reset;

    int   n_cmp = 0;
    int   n_err = 0;

    logic exp_q[$];
    logic got_q[$];
    int   valid_cnt;
    int   err_cnt;
    int   eop_cnt;
    int   rst_cnt;
    logic tb_level;

    usb_rx_nrzi_unstuff dut (
        .clk          (clk),
        .rst          (rst),
        .rx_enable    (rx_enable),
        .bit_strobe   (bit_strobe),
        .line_j       (line_j),
        .line_se0     (line_se0),
        .data_valid   (data_valid),
        .data_in      (data_in),
        .rx_active    (rx_active),
        .stuff_err    (stuff_err),
        .eop_detected (eop_detected),
        .usb_reset    (usb_reset)
    );

    always #5 clk = ~clk;

    task automatic clear_obs();
        exp_q.delete();
        got_q.delete();
        valid_cnt = 0;
        err_cnt   = 0;
        eop_cnt   = 0;
        rst_cnt   = 0;
    endtask

    // Record whatever the DUT produced this cycle.
    task automatic sample();
        if (data_valid === 1'b1) begin
            got_q.push_back(data_in);
            valid_cnt++;
        end
        if (stuff_err === 1'b1)    err_cnt++;
        if (eop_detected === 1'b1) eop_cnt++;
        if (usb_reset === 1'b1)    rst_cnt++;
    endtask

    // One bit strobe followed by 'gap' idle clocks, sampling every cycle.
    task automatic strobe(input logic se0, input logic j, input int gap);
        line_se0   = se0;
        line_j     = se0 ? 1'b0 : j;
        bit_strobe = 1'b1;
        @(posedge clk); #1;
        bit_strobe = 1'b0;
        sample();
        for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
            sample();
        end
    endtask

    // NRZI-encode one data bit; 'emit' says whether it should reach data_in.
    task automatic send_bit(input logic b, input logic emit, input int gap);
        if (b == 1'b0) tb_level = ~tb_level;
        strobe(1'b0, tb_level, gap);
        if (emit) exp_q.push_back(b);
    endtask

    // First n line levels of SYNC (K J K J K J K K), decoding to 0000_0001.
    task automatic send_sync(input int n, input int gap);
        logic [7:0] lv;
        lv = 8'b0010_1010;
        for (int i = 0; i < n; i++) begin
            strobe(1'b0, lv[i], gap);
            exp_q.push_back((i == 7) ? 1'b1 : 1'b0);
        end
        tb_level = 1'b0;
    endtask

    task automatic send_eop(input int gap);
        strobe(1'b1, 1'b0, gap);
        strobe(1'b1, 1'b0, gap);
        strobe(1'b0, 1'b1, gap);
        tb_level = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; rx_enable = 1'b1; bit_strobe = 1'b0;
        line_j = 1'b1; line_se0 = 1'b0; tb_level = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (data_valid !== 1'b0)   begin n_err++; $display("FAIL reset_data_valid: got %b want 0", data_valid); end
        n_cmp++; if (data_in !== 1'b0)      begin n_err++; $display("FAIL reset_data_in: got %b want 0", data_in); end
        n_cmp++; if (rx_active !== 1'b0)    begin n_err++; $display("FAIL reset_rx_active: got %b want 0", rx_active); end
        n_cmp++; if (stuff_err !== 1'b0)    begin n_err++; $display("FAIL reset_stuff_err: got %b want 0", stuff_err); end
        n_cmp++; if (eop_detected !== 1'b0) begin n_err++; $display("FAIL reset_eop: got %b want 0", eop_detected); end
        n_cmp++; if (usb_reset !== 1'b0)    begin n_err++; $display("FAIL reset_usb_reset: got %b want 0", usb_reset); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_sync_eop();
        logic e, g;
        clear_obs();
        repeat (3) strobe(1'b0, 1'b1, 2);
        n_cmp++; if (valid_cnt != 0) begin n_err++; $display("FAIL idle_j_valid: got %0d pulses want 0", valid_cnt); end
        strobe(1'b0, 1'b0, 0);
        exp_q.push_back(1'b0);
        n_cmp++; if (rx_active !== 1'b1) begin n_err++; $display("FAIL sync_rx_active: got %b want 1", rx_active); end
        // Remaining SYNC levels after the first K.
        strobe(1'b0, 1'b1, 2); exp_q.push_back(1'b0);
        strobe(1'b0, 1'b0, 2); exp_q.push_back(1'b0);
        strobe(1'b0, 1'b1, 2); exp_q.push_back(1'b0);
        strobe(1'b0, 1'b0, 2); exp_q.push_back(1'b0);
        strobe(1'b0, 1'b1, 2); exp_q.push_back(1'b0);
        strobe(1'b0, 1'b0, 2); exp_q.push_back(1'b0);
        strobe(1'b0, 1'b0, 2); exp_q.push_back(1'b1);
        tb_level = 1'b0;
        send_eop(2);
        n_cmp++; if (valid_cnt != 8)     begin n_err++; $display("FAIL sync_valid_cnt: got %0d want 8", valid_cnt); end
        n_cmp++; if (eop_cnt != 1)       begin n_err++; $display("FAIL sync_eop_cnt: got %0d want 1", eop_cnt); end
        n_cmp++; if (err_cnt != 0)       begin n_err++; $display("FAIL sync_stuff_err: got %0d want 0", err_cnt); end
        n_cmp++; if (rx_active !== 1'b0) begin n_err++; $display("FAIL sync_rx_active_end: got %b want 0", rx_active); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++; if (g !== e) begin n_err++; $display("FAIL sync_bit: got %b want %b", g, e); end
        end
    endtask

    // SYNC ends on a decoded 1, so a 0 precedes the run to start it from zero.
    task automatic test_stuffing();
        logic e, g;
        clear_obs();
        send_sync(8, 1);
        send_bit(1'b0, 1'b1, 1);
        repeat (6) send_bit(1'b1, 1'b1, 1);
        send_bit(1'b0, 1'b0, 1);
        send_bit(1'b0, 1'b1, 1);
        send_eop(1);
        n_cmp++; if (valid_cnt != 16) begin n_err++; $display("FAIL stuff_valid_cnt: got %0d want 16", valid_cnt); end
        n_cmp++; if (err_cnt != 0)    begin n_err++; $display("FAIL stuff_err_cnt: got %0d want 0", err_cnt); end
        n_cmp++; if (eop_cnt != 1)    begin n_err++; $display("FAIL stuff_eop_cnt: got %0d want 1", eop_cnt); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++; if (g !== e) begin n_err++; $display("FAIL stuff_bit: got %b want %b", g, e); end
        end
    endtask

    task automatic test_stuff_error();
        logic e, g;
        clear_obs();
        send_sync(8, 1);
        send_bit(1'b0, 1'b1, 1);
        repeat (6) send_bit(1'b1, 1'b1, 1);
        send_bit(1'b1, 1'b0, 1);
        n_cmp++; if (err_cnt != 1)       begin n_err++; $display("FAIL err_pulse: got %0d want 1", err_cnt); end
        send_bit(1'b0, 1'b0, 1);
        send_bit(1'b1, 1'b0, 1);
        send_bit(1'b0, 1'b0, 1);
        n_cmp++; if (rx_active !== 1'b1) begin n_err++; $display("FAIL err_rx_active: got %b want 1", rx_active); end
        send_eop(1);
        n_cmp++; if (valid_cnt != 15)    begin n_err++; $display("FAIL err_valid_cnt: got %0d want 15", valid_cnt); end
        n_cmp++; if (eop_cnt != 1)       begin n_err++; $display("FAIL err_eop_cnt: got %0d want 1", eop_cnt); end
        n_cmp++; if (err_cnt != 1)       begin n_err++; $display("FAIL err_total: got %0d want 1", err_cnt); end
        n_cmp++; if (rx_active !== 1'b0) begin n_err++; $display("FAIL err_idle: got %b want 0", rx_active); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++; if (g !== e) begin n_err++; $display("FAIL err_bit: got %b want %b", g, e); end
        end
    endtask

    task automatic test_bus_reset();
        logic e, g;
        clear_obs();
        repeat (29) strobe(1'b1, 1'b0, 1);
        n_cmp++; if (rst_cnt != 0) begin n_err++; $display("FAIL busrst_early: got %0d want 0", rst_cnt); end
        strobe(1'b1, 1'b0, 1);
        n_cmp++; if (rst_cnt != 1) begin n_err++; $display("FAIL busrst_pulse: got %0d want 1", rst_cnt); end
        repeat (10) strobe(1'b1, 1'b0, 1);
        n_cmp++; if (rst_cnt != 1) begin n_err++; $display("FAIL busrst_repeat: got %0d want 1", rst_cnt); end
        strobe(1'b0, 1'b1, 1);
        // A second full SE0 run only pulses if the J cleared the count.
        repeat (30) strobe(1'b1, 1'b0, 0);
        n_cmp++; if (rst_cnt != 2) begin n_err++; $display("FAIL busrst_recount: got %0d want 2", rst_cnt); end
        strobe(1'b0, 1'b1, 1);
        tb_level = 1'b1;
        send_sync(8, 1);
        repeat (30) strobe(1'b1, 1'b0, 0);
        n_cmp++; if (rst_cnt != 3)       begin n_err++; $display("FAIL busrst_active: got %0d want 3", rst_cnt); end
        n_cmp++; if (rx_active !== 1'b0) begin n_err++; $display("FAIL busrst_rx_active: got %b want 0", rx_active); end
        strobe(1'b0, 1'b1, 1);
        tb_level = 1'b1;
        n_cmp++; if (eop_cnt != 0)       begin n_err++; $display("FAIL busrst_eop: got %0d want 0", eop_cnt); end
        n_cmp++; if (valid_cnt != 8)     begin n_err++; $display("FAIL busrst_valid: got %0d want 8", valid_cnt); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++; if (g !== e) begin n_err++; $display("FAIL busrst_bit: got %b want %b", g, e); end
        end
    endtask

    task automatic test_enable_drop();
        logic e, g;
        clear_obs();
        send_sync(4, 1);
        rx_enable = 1'b0;
        @(posedge clk); #1;
        sample();
        n_cmp++; if (rx_active !== 1'b0) begin n_err++; $display("FAIL endrop_rx_active: got %b want 0", rx_active); end
        strobe(1'b0, 1'b0, 1);
        strobe(1'b1, 1'b0, 1);
        strobe(1'b0, 1'b1, 1);
        n_cmp++; if (eop_cnt != 0)       begin n_err++; $display("FAIL endrop_eop: got %0d want 0", eop_cnt); end
        rx_enable = 1'b1;
        @(posedge clk); #1;
        tb_level = 1'b1;
        send_sync(8, 1);
        send_eop(1);
        n_cmp++; if (valid_cnt != 12) begin n_err++; $display("FAIL endrop_valid: got %0d want 12", valid_cnt); end
        n_cmp++; if (eop_cnt != 1)    begin n_err++; $display("FAIL endrop_eop_end: got %0d want 1", eop_cnt); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++; if (g !== e) begin n_err++; $display("FAIL endrop_bit: got %b want %b", g, e); end
        end
    endtask

    // Back-to-back strobes; reset lands on the same edge as a data strobe.
    task automatic test_back_to_back_rst();
        logic e, g;
        clear_obs();
        send_sync(8, 0);
        repeat (4) send_bit(1'b1, 1'b1, 0);
        line_se0 = 1'b0; line_j = tb_level; bit_strobe = 1'b1; rst = 1'b0;
        @(posedge clk); #1;
        bit_strobe = 1'b0;
        n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b want 0", data_valid); end
        n_cmp++; if (rx_active !== 1'b0)  begin n_err++; $display("FAIL rst_mid_active: got %b want 0", rx_active); end
        n_cmp++; if (stuff_err !== 1'b0)  begin n_err++; $display("FAIL rst_mid_err: got %b want 0", stuff_err); end
        rst = 1'b1;
        @(posedge clk); #1;
        tb_level = 1'b1;
        send_sync(8, 0);
        send_eop(0);
        n_cmp++; if (valid_cnt != 20) begin n_err++; $display("FAIL rst_valid_cnt: got %0d want 20", valid_cnt); end
        n_cmp++; if (err_cnt != 0)    begin n_err++; $display("FAIL rst_stuff_err: got %0d want 0", err_cnt); end
        n_cmp++; if (eop_cnt != 1)    begin n_err++; $display("FAIL rst_eop_cnt: got %0d want 1", eop_cnt); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++; if (g !== e) begin n_err++; $display("FAIL rst_bit: got %b want %b", g, e); end
        end
    endtask

    initial begin
        test_reset();
        test_sync_eop();
        test_stuffing();
        test_stuff_error();
        test_bus_reset();
        test_enable_drop();
        test_back_to_back_rst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
